// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  // Default text segment bounds (byte addresses, TEXT_END is the last legal word).
  localparam logic [31:0] TEXT_BEGIN        = 32'h0040_0000;
  localparam logic [31:0] TEXT_END          = 32'h0040_1FFC;

  // Word handed to decode for faulting fetches; memory data is never forwarded.
  localparam logic [31:0] FETCH_FAULT_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with synchronous flush and a registered head copy,
// so the head outputs are pure flops and hold their last value when the FIFO drains.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push    = push && ((count != FULL) || do_pop);
  assign rd_next    = rd_ptr + 1'b1;

  // Storage array; no reset needed since nothing reads a slot before it is written.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered head copy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
      // The next head is either the following stored slot or, if the FIFO
      // would otherwise be empty, the word being pushed this cycle.
      if (do_pop) begin
        if (count == ONE) begin
          if (do_push) head <= push_data;
        end else begin
          head <= mem[rd_next];
        end
      end else if (!head_valid && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word reads to the text memory,
// absorbs the one-cycle read latency and queues results for decode.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = TEXT_BEGIN,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] TEXT_LO    = TEXT_BEGIN,
  parameter logic [31:0] TEXT_HI    = TEXT_END
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic [31:0] instr,
  output logic        instr_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          inflight_fault;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic [CW:0]   limit;
  logic          pop;
  logic          issue;
  logic          fault;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  assign imem_address = fetch_pc;
  assign pop          = instr_valid && instr_ready;
  assign fault        = (fetch_pc < TEXT_LO) || (fetch_pc > TEXT_HI) || (fetch_pc[1:0] != 2'b00);

  // Credit check: buffered plus in-flight words must leave room for the new one.
  // A head leaving this cycle frees its slot before the new word can land,
  // which is what allows one word per cycle with a two-entry FIFO.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign limit = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
  assign issue = !redirect_valid && (used < limit);

  assign push_data = '{pc:    inflight_pc,
                       instr: inflight_fault ? FETCH_FAULT_INSTR : imem_data,
                       fault: inflight_fault};

  // Fetch PC and in-flight tracking; redirect discards the outstanding read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_fault <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc       <= fetch_pc + 32'd4;
      inflight       <= 1'b1;
      inflight_pc    <= fetch_pc;
      inflight_fault <= fault;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (inflight),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .head_valid (instr_valid),
    .count      (count)
  );

  assign instr_pc    = head.pc;
  assign instr       = head.instr;
  assign instr_fault = head.fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int          FDEPTH = 2;
  localparam logic [31:0] LO     = TEXT_BEGIN;
  localparam logic [31:0] HI     = TEXT_END;
  localparam logic [31:0] RPC    = TEXT_BEGIN;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_pc;
  logic [31:0] instr;
  logic        instr_fault;

  int checks = 0;
  int fails  = 0;
  int pops   = 0;
  int p0;
  logic [31:0] exp_pc;
  logic [31:0] held_addr;

  instruction_fetch_unit #(
    .RESET_PC(RPC), .FIFO_DEPTH(FDEPTH), .TEXT_LO(LO), .TEXT_HI(HI)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_pc       (instr_pc),
    .instr          (instr),
    .instr_fault    (instr_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] image_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic ref_fault(input logic [31:0] a);
    return (a < LO) || (a > HI) || (a % 4 != 0);
  endfunction

  // Synchronous text memory: garbage for illegal addresses so leakage is visible.
  always @(posedge clock)
    imem_data <= ref_fault(imem_address) ? 32'hDEAD_BEEF : image_word(imem_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: apply inputs, score any entry decode takes at this edge, advance model.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge clock);
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    #1;
    if (instr_valid && rdy) begin
      check("pop_pc",    instr_pc,           exp_pc);
      check("pop_instr", instr,              ref_fault(exp_pc) ? 32'h0 : image_word(exp_pc));
      check("pop_fault", {31'b0, instr_fault}, {31'b0, ref_fault(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redir) exp_pc = tgt;
    @(posedge clock);
    #1;
    if (redir) begin
      check("redir_valid_low", {31'b0, instr_valid}, 32'd0);
      check("redir_addr",      imem_address,         tgt);
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0);
  endtask

  task automatic first_valid_timing();
    @(posedge clock); #1;
    check("first_valid_c1", {31'b0, instr_valid}, 32'd0);
    @(posedge clock); #1;
    check("first_valid_c2", {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    exp_pc = RPC;
    repeat (3) @(negedge clock);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc",    instr_pc,             32'd0);
    check("rst_instr", instr,                32'd0);
    check("rst_fault", {31'b0, instr_fault}, 32'd0);
    check("rst_addr",  imem_address,         RPC);

    // Release with decode always ready.
    @(negedge clock);
    reset = 1'b1; instr_ready = 1'b1;
    first_valid_timing();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check("sustain_valid", {31'b0, instr_valid}, 32'd1);
      check("sustain_addr",  imem_address,         exp_pc + 32'd8);
    end

    // Decode stalls: FIFO fills to depth, fetch address freezes.
    run(3, 1'b0);
    held_addr = imem_address;
    run(3, 1'b0);
    check("stall_frozen", imem_address,         held_addr);
    check("stall_fill",   imem_address,         exp_pc + 32'(4 * FDEPTH));
    check("stall_valid",  {31'b0, instr_valid}, 32'd1);
    p0 = pops;
    run(8, 1'b1);
    check("resume_progress", {31'b0, 1'(pops - p0 >= 6)}, 32'd1);

    // Redirect while streaming (buffered entry plus read in flight), with a pop.
    step(1'b1, 1'b1, 32'h0040_0100);
    p0 = pops;
    run(6, 1'b1);
    // Redirect with a full FIFO.
    run(3, 1'b0);
    step(1'b0, 1'b1, 32'h0040_0180);
    run(6, 1'b1);
    // Redirect plus pop, then a second redirect right behind it.
    step(1'b1, 1'b1, 32'h0040_0200);
    step(1'b1, 1'b1, 32'h0040_0300);
    run(6, 1'b1);
    check("redir_progress", {31'b0, 1'(pops - p0 >= 12)}, 32'd1);

    // Misaligned target and the top of the text segment.
    p0 = pops;
    step(1'b1, 1'b1, 32'h0040_0102);
    run(5, 1'b1);
    step(1'b1, 1'b1, HI - 32'd4);
    run(6, 1'b1);
    check("edge_progress", {31'b0, 1'(pops - p0 >= 8)}, 32'd1);

    // Random decode back-pressure and redirects.
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = LO - 32'h40 + 32'($urandom_range(0, 2100)) * 32'd4;
      if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd2;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
    end
    check("random_progress", {31'b0, 1'(pops - p0 >= 100)}, 32'd1);

    // Reset in the middle of a stream.
    run(4, 1'b1);
    @(negedge clock);
    check("pre_reset_valid", {31'b0, instr_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_valid", {31'b0, instr_valid}, 32'd0);
    check("async_pc",    instr_pc,             32'd0);
    check("async_addr",  imem_address,         RPC);
    @(negedge clock);
    reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    exp_pc = RPC;
    first_valid_timing();
    p0 = pops;
    run(10, 1'b1);
    check("restart_progress", {31'b0, 1'(pops - p0 >= 9)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
